// File: rtl/riscv_pkg.sv
// Shared pipeline constants: default widths, the x0 register index and the
// field values a bubble loads into the ID/EX register.
package riscv_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W      = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic       BUBBLE_FLAG = 1'b0;
  localparam logic [4:0] BUBBLE_ADDR = REG_X0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: an ID instruction reads the destination of a load
// currently in EX, so it must wait one cycle for the load data.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  output logic       load_use
);
  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != REG_X0) &&
                    id_valid && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush-to-bubble, WB
// write-through on operand capture, and saturating stall/flush counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd_addr,
  input  logic [XLEN-1:0]   wb_rd_val,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic            load_use, capture, wb_fwd_ok, reg_write_n;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

  hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .load_use    (load_use)
  );

  // Flush kills the ID instruction outright, so there is nothing to hold.
  assign stall   = load_use && !ex_flush;
  assign capture = id_valid && !ex_flush && !stall;

  // Regfile write lands this cycle; the read port still shows the old value.
  assign wb_fwd_ok   = wb_reg_write && (wb_rd_addr != REG_X0);
  assign rs1_sel     = (wb_fwd_ok && wb_rd_addr == id_rs1_addr) ? wb_rd_val : id_rs1_val;
  assign rs2_sel     = (wb_fwd_ok && wb_rd_addr == id_rs2_addr) ? wb_rd_val : id_rs2_val;
  assign reg_write_n = id_reg_write && (id_rd_addr != REG_X0);

  always_ff @(posedge clk) begin
    if (rst || !capture) begin
      ex_valid     <= BUBBLE_FLAG;
      ex_reg_write <= BUBBLE_FLAG;
      ex_mem_read  <= BUBBLE_FLAG;
      ex_mem_write <= BUBBLE_FLAG;
      ex_rd_addr   <= BUBBLE_ADDR;
      ex_rs1_addr  <= BUBBLE_ADDR;
      ex_rs2_addr  <= BUBBLE_ADDR;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_ctrl      <= '0;
    end else begin
      ex_valid     <= 1'b1;
      ex_reg_write <= reg_write_n;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      // Non-writers carry rd=x0 so address-only compares downstream never hit.
      ex_rd_addr   <= reg_write_n ? id_rd_addr : REG_X0;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_val   <= rs1_sel;
      ex_rs2_val   <= rs2_sel;
      ex_ctrl      <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)                stall_cnt <= sat_inc(stall_cnt);
      if (ex_flush && id_valid) flush_cnt <= sat_inc(flush_cnt);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stall, x0/unused operands,
// flush priority, WB write-through, rd normalization and reset mid-stall.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic              id_uses_rs1, id_uses_rs2;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_val;
  logic              ex_flush;
  logic              stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [XLEN-1:0]   ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]        ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .ex_flush(ex_flush), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [31:0] v1, input logic [31:0] v2,
                       input logic rw, input logic mr);
    id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_val = v1; id_rs2_val = v2;
    id_imm = pc + 32'h10; id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_ctrl = pc[7:0] ^ 8'h5A;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_flush = 1'b0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_val = '0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    chk("rst_ex_valid", {31'd0, ex_valid}, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    // Load-use: lw x5 then add x7, x5, x6
    drive(1, 32'h100, 5'd2, 5'd0, 5'd5, 1, 0, 32'h1, 32'h0, 1, 1);
    step();
    chk("lw_valid", {31'd0, ex_valid}, 1);
    chk("lw_mem_read", {31'd0, ex_mem_read}, 1);
    chk("lw_rd", {27'd0, ex_rd_addr}, 5);
    chk("lw_imm", ex_imm, 32'h110);
    chk("lw_ctrl", {24'd0, ex_ctrl}, 32'h5A);
    drive(1, 32'h104, 5'd5, 5'd6, 5'd7, 1, 1, 32'h10, 32'h20, 1, 0);
    chk("lu_stall", {31'd0, stall}, 1);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
    chk("lu_bubble_pc", ex_pc, 0);
    chk("lu_stall_clear", {31'd0, stall}, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    step();
    chk("lu_cap_valid", {31'd0, ex_valid}, 1);
    chk("lu_cap_pc", ex_pc, 32'h104);
    chk("lu_cap_rs1", ex_rs1_val, 32'h10);
    chk("lu_cap_rd", {27'd0, ex_rd_addr}, 7);
    chk("lu_cap_stall_cnt", stall_cnt, 1);

    // Load to x0 followed by a reader of x0: no stall
    drive(1, 32'h200, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 1, 1);
    step();
    drive(1, 32'h204, 5'd0, 5'd0, 5'd8, 1, 0, 0, 0, 1, 0);
    chk("x0_stall", {31'd0, stall}, 0);
    step();
    chk("x0_cap_pc", ex_pc, 32'h204);
    // rs2 matches the load but is not read
    drive(1, 32'h208, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 1, 1);
    step();
    drive(1, 32'h20C, 5'd3, 5'd5, 5'd9, 1, 0, 0, 0, 1, 0);
    chk("unused_stall", {31'd0, stall}, 0);
    step();
    chk("unused_cap_valid", {31'd0, ex_valid}, 1);
    chk("unused_cap_pc", ex_pc, 32'h20C);

    // Flush beats load-use
    do_reset();
    drive(1, 32'h300, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 1, 1);
    step();
    drive(1, 32'h304, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
    ex_flush = 1'b1; #1;
    chk("fl_stall", {31'd0, stall}, 0);
    step();
    ex_flush = 1'b0;
    chk("fl_bubble", {31'd0, ex_valid}, 0);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 0);

    // WB write-through
    drive(1, 32'h400, 5'd3, 5'd7, 5'd10, 1, 1, 32'h55, 32'h0, 1, 0);
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_rd_val = 32'hDEADBEEF;
    step();
    chk("wb_rs2_fwd", ex_rs2_val, 32'hDEADBEEF);
    chk("wb_rs1_keep", ex_rs1_val, 32'h55);
    drive(1, 32'h404, 5'd3, 5'd0, 5'd10, 1, 1, 32'h66, 32'h0, 1, 0);
    wb_rd_addr = 5'd0;
    step();
    chk("wb_x0_rs2", ex_rs2_val, 0);
    drive(1, 32'h408, 5'd4, 5'd2, 5'd10, 1, 1, 32'h77, 32'h88, 1, 0);
    wb_rd_addr = 5'd4; wb_rd_val = 32'hCAFE0001;
    step();
    chk("wb_rs1_fwd", ex_rs1_val, 32'hCAFE0001);
    chk("wb_rs2_keep", ex_rs2_val, 32'h88);
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_val = '0;

    // rd normalization
    drive(1, 32'h500, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 1, 0);
    step();
    chk("rd0_reg_write", {31'd0, ex_reg_write}, 0);
    chk("rd0_rd", {27'd0, ex_rd_addr}, 0);
    drive(1, 32'h504, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 0, 0);
    step();
    chk("nowr_rd", {27'd0, ex_rd_addr}, 0);
    chk("nowr_valid", {31'd0, ex_valid}, 1);
    drive(1, 32'h508, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 1, 0);
    step();
    chk("wr_rd", {27'd0, ex_rd_addr}, 9);
    chk("wr_reg_write", {31'd0, ex_reg_write}, 1);
    drive(0, 32'h50C, 5'd1, 5'd2, 5'd9, 1, 1, 32'h3, 32'h4, 1, 0);
    step();
    chk("inv_bubble", {31'd0, ex_valid}, 0);
    chk("inv_rs1_val", ex_rs1_val, 0);

    // Reset while stalled
    drive(1, 32'h600, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 1, 1);
    step();
    drive(1, 32'h604, 5'd5, 5'd0, 5'd6, 1, 0, 32'h9, 0, 1, 0);
    chk("rs_pre_stall", {31'd0, stall}, 1);
    chk("rs_pre_flush_cnt", flush_cnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("rs_valid", {31'd0, ex_valid}, 0);
    chk("rs_mem_read", {31'd0, ex_mem_read}, 0);
    chk("rs_pc", ex_pc, 0);
    chk("rs_imm", ex_imm, 0);
    chk("rs_stall", {31'd0, stall}, 0);
    chk("rs_stall_cnt", stall_cnt, 0);
    chk("rs_flush_cnt", flush_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width of register values, PC and immediate.
REQ-002 SHALL have parameter: CTRL_W, 8, width of opaque EX/MEM control bundle (ALU op, src selects).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset (one clock; reset synchronous, active-high).
REQ-004 SHALL have ID inputs: id_valid in 1; id_pc in XLEN; id_rs1_addr, id_rs2_addr, id_rd_addr in 5 each; id_uses_rs1, id_uses_rs2 in 1 each (operand read by instruction); id_rs1_val, id_rs2_val in XLEN (regfile read data); id_imm in XLEN; id_reg_write, id_mem_read, id_mem_write in 1 each; id_ctrl in CTRL_W.
REQ-005 SHALL have WB inputs: wb_reg_write in 1; wb_rd_addr in 5; wb_rd_val in XLEN (same-cycle regfile write).
REQ-006 SHALL have ex_flush in 1: taken branch/jump resolved in EX; kill instruction in ID.
REQ-007 SHALL have outputs: stall out 1 (hold PC and IF/ID); ex_valid, ex_reg_write, ex_mem_read, ex_mem_write out 1 each; ex_pc, ex_rs1_val, ex_rs2_val, ex_imm out XLEN; ex_rs1_addr, ex_rs2_addr, ex_rd_addr out 5 each; ex_ctrl out CTRL_W; stall_cnt, flush_cnt out 32 each.

Function
REQ-008 SHALL register all ex_* outputs on clk rising edge; ID->EX latency exactly 1 cycle.
REQ-009 SHALL assert stall combinationally when load_use = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)), and ex_flush=0.
REQ-010 SHALL, when ex_flush=1, deassert stall and load a bubble (flush wins over load_use).
REQ-011 SHALL, when stall=1, load a bubble; the stalled instruction is re-presented by upstream next cycle and captured then.
REQ-012 SHALL define bubble as: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; ex_rd_addr, ex_rs1_addr, ex_rs2_addr = 0; ex_pc, ex_imm, ex_rs*_val, ex_ctrl = 0.
REQ-013 SHALL load a bubble when id_valid=0.
REQ-014 SHALL, for a captured instruction, substitute wb_rd_val for ex_rs1_val (ex_rs2_val) when wb_reg_write=1, wb_rd_addr!=0, wb_rd_addr==id_rs1_addr (id_rs2_addr); else capture id_rs*_val.
REQ-015 SHALL drive ex_rd_addr=0 whenever captured ex_reg_write=0, and force ex_reg_write=0 when id_rd_addr=0, so downstream address-only rd compares never match x0 or non-writers.
REQ-016 SHALL never produce stall on two consecutive cycles for the same load (bubble clears ex_mem_read).
REQ-017 SHALL increment stall_cnt by 1 each cycle stall=1, saturating at 0xFFFF_FFFF.
REQ-018 SHALL increment flush_cnt by 1 each cycle ex_flush=1 and id_valid=1, saturating at 0xFFFF_FFFF.

Reset
REQ-019 SHALL, on rst=1 at clk edge, load a bubble into all ex_* registers and clear stall_cnt, flush_cnt to 0; rst dominates ex_flush and stall.
REQ-020 SHALL drive stall=0 in the cycle after reset (ex_valid=0 blocks load_use).

Structure
REQ-021 SHALL place XLEN default, CTRL_W default, REG_X0 (5'd0) and bubble field values in shared package riscv_pkg.
REQ-022 SHALL implement load-use detection as combinational sub-module hazard_detect; counters and pipeline register in id_ex_stage.

Verification
REQ-023 SHALL test load-use: EX lw x5 (mem_read=1, rd=5), ID add uses rs1=5 -> stall=1 one cycle, next ex_valid=0, following cycle add captured, stall=0, stall_cnt=1.
REQ-024 SHALL test x0/unused: EX lw rd=0 with ID rs1=0, or ID id_uses_rs2=0 with rs2 match -> stall=0, instruction captured next cycle.
REQ-025 SHALL test flush vs stall: load_use true and ex_flush=1 same cycle -> stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
REQ-026 SHALL test WB write-through: wb_reg_write=1, wb_rd_addr=7, wb_rd_val=0xDEADBEEF, id_rs2_addr=7, id_rs2_val=0 -> ex_rs2_val=0xDEADBEEF; same with wb_rd_addr=0 -> ex_rs2_val=0.
REQ-027 SHALL test rd normalization: id_rd_addr=0, id_reg_write=1 -> ex_reg_write=0, ex_rd_addr=0; id_reg_write=0, id_rd_addr=9 -> ex_rd_addr=0.
REQ-028 SHALL test reset mid-stall: rst=1 while stall=1 -> next cycle all ex_* bubble, counters 0, stall=0.
